// File: rtl/dmem_copy_if.sv
// Bundle of the request/status signals and the dmem port driven by the block copier.
// The copier takes the master side; the requester plus the dmem model take the slave side.
interface dmem_copy_if;
    // request side
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic [7:0] pattern;
    logic       busy;
    logic       done;
    // dmem side
    logic [3:0] kind;
    logic [1:0] fn2;
    logic [7:0] rd1;
    logic [7:0] disp;
    logic [7:0] store_d;
    logic [7:0] load_d;

    modport master (
        input  start, mode, src, dst, len, pattern, load_d,
        output busy, done, kind, fn2, rd1, disp, store_d
    );

    modport slave (
        output start, mode, src, dst, len, pattern, load_d,
        input  busy, done, kind, fn2, rd1, disp, store_d
    );
endinterface

// File: rtl/dmem_copy.sv
// Block-transfer initiator for the data memory port: byte-serial ascending copy or fill,
// one load (RD) and one committed store (WR, on an edge with ck2 low) per byte.
module dmem_copy #(
    parameter logic [3:0] KIND_MEM = 4'b0011,
    parameter logic [1:0] FN2_LD   = 2'b00,
    parameter logic [1:0] FN2_ST   = 2'b01
) (
    input  logic        ck,
    input  logic        res,
    input  logic        ck2,
    dmem_copy_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t     state_reg,   state_next;
    logic [8:0] cnt_reg,     cnt_next;
    logic [7:0] buf_reg,     buf_next;
    logic [7:0] src_reg,     src_next;
    logic [7:0] dst_reg,     dst_next;
    logic [8:0] len_reg,     len_next;
    logic       mode_reg,    mode_next;
    logic [7:0] pattern_reg, pattern_next;

    logic [8:0] cnt_inc;

    logic       busy_c;
    logic       done_c;
    logic [3:0] kind_c;
    logic [1:0] fn2_c;
    logic [7:0] rd1_c;
    logic [7:0] disp_c;
    logic [7:0] store_c;

    assign cnt_inc = cnt_reg + 9'd1;

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            buf_reg     <= '0;
            src_reg     <= '0;
            dst_reg     <= '0;
            len_reg     <= '0;
            mode_reg    <= 1'b0;
            pattern_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            buf_reg     <= buf_next;
            src_reg     <= src_next;
            dst_reg     <= dst_next;
            len_reg     <= len_next;
            mode_reg    <= mode_next;
            pattern_reg <= pattern_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        buf_next     = buf_reg;
        src_next     = src_reg;
        dst_next     = dst_reg;
        len_next     = len_reg;
        mode_next    = mode_reg;
        pattern_next = pattern_reg;

        busy_c  = 1'b0;
        done_c  = 1'b0;
        kind_c  = 4'b0000;
        fn2_c   = 2'b00;
        rd1_c   = 8'h00;
        disp_c  = 8'h00;
        store_c = 8'h00;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    src_next     = bus.src;
                    dst_next     = bus.dst;
                    len_next     = bus.len;
                    mode_next    = bus.mode;
                    pattern_next = bus.pattern;
                    cnt_next     = '0;
                    if (bus.len == 9'd0) begin
                        state_next = FIN;
                    end else if (bus.mode) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end

            RD: begin
                busy_c     = 1'b1;
                kind_c     = KIND_MEM;
                fn2_c      = FN2_LD;
                rd1_c      = src_reg;
                disp_c     = cnt_reg[7:0];
                buf_next   = bus.load_d;
                state_next = WR;
            end

            WR: begin
                busy_c  = 1'b1;
                kind_c  = KIND_MEM;
                fn2_c   = FN2_ST;
                rd1_c   = dst_reg;
                disp_c  = cnt_reg[7:0];
                store_c = mode_reg ? pattern_reg : buf_reg;
                // dmem only commits on an edge with ck2 low; hold everything otherwise
                if (!ck2) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == len_reg) begin
                        state_next = FIN;
                    end else if (mode_reg) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end

            FIN: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // outputs decode from state only, so async reset zeroes them immediately
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.kind    = kind_c;
    assign bus.fn2     = fn2_c;
    assign bus.rd1     = rd1_c;
    assign bus.disp    = disp_c;
    assign bus.store_d = store_c;

endmodule

// File: tb/tb_dmem_copy.sv
// Bench for dmem_copy: a 256-byte dmem model plus a forward-copy/fill reference array,
// with directed scenarios followed by randomized transfers.
module tb_dmem_copy;

    logic ck  = 1'b0;
    logic res = 1'b0;
    logic ck2 = 1'b0;

    dmem_copy_if bus ();

    dmem_copy dut (
        .ck  (ck),
        .res (res),
        .ck2 (ck2),
        .bus (bus)
    );

    always #5 ck = ~ck;

    logic [7:0] mem     [256];
    logic [7:0] pre_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ea;
    bit         pre_load = 1'b0;
    int         ck2_mode = 0;     // 0 alternate, 1 held high, 2 random

    int wr_count   = 0;
    int done_count = 0;
    int busy_count = 0;
    int acc_count  = 0;
    int total      = 0;
    int bad        = 0;

    assign ea         = bus.rd1 + bus.disp;
    assign bus.load_d = mem[ea];

    always @(negedge ck) begin
        case (ck2_mode)
            0:       ck2 <= ~ck2;
            1:       ck2 <= 1'b1;
            default: ck2 <= 1'($urandom_range(0, 1));
        endcase
    end

    // dmem model and activity counters
    always @(posedge ck) begin
        if (pre_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre_mem[i];
        end else if (bus.kind == 4'b0011 && bus.fn2 == 2'b01 && !ck2) begin
            mem[ea]  <= bus.store_d;
            wr_count <= wr_count + 1;
        end
        if (bus.done)             done_count <= done_count + 1;
        if (bus.busy)             busy_count <= busy_count + 1;
        if (bus.kind == 4'b0011)  acc_count  <= acc_count + 1;
    end

    function automatic int mem_diff(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic randomize_pre();
        for (int i = 0; i < 256; i++) pre_mem[i] = 8'($urandom);
    endtask

    task automatic load_mem();
        pre_load = 1'b1;
        @(posedge ck);
        #1;
        pre_load = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pre_mem[i];
        @(negedge ck);
    endtask

    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int l);
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < l; i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            ref_mem[b] = ref_mem[a];
        end
    endtask

    task automatic ref_fill(input logic [7:0] d, input int l, input logic [7:0] p);
        logic [7:0] b;
        for (int i = 0; i < l; i++) begin
            b = d + 8'(i);
            ref_mem[b] = p;
        end
    endtask

    // called at a negedge; returns at the negedge just after the start edge
    task automatic start_xfer(input bit m, input logic [7:0] s, input logic [7:0] d,
                              input logic [8:0] l, input logic [7:0] p);
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.src     = s;
        bus.dst     = d;
        bus.len     = l;
        bus.pattern = p;
        @(negedge ck);
        bus.start   = 1'b0;
        $display("xfer mode=%0d src=%02h dst=%02h len=%0d pattern=%02h", m, s, d, l, p);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge ck);
            n++;
        end
        ok = (bus.done === 1'b1);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.pattern = '0;
        res = 1'b0;
        repeat (3) @(negedge ck);
        total++;
        if ({bus.busy, bus.done, bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d} !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus.busy, bus.done, bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d});
        end
        res = 1'b1;
        @(negedge ck);
    endtask

    task automatic test_copy();
        int d0, w0, first, nd;
        bit ok;
        randomize_pre();
        pre_mem[8'h10] = 8'hA1; pre_mem[8'h11] = 8'hB2;
        pre_mem[8'h12] = 8'hC3; pre_mem[8'h13] = 8'hD4;
        load_mem();
        ck2_mode = 0;
        d0 = done_count; w0 = wr_count;
        start_xfer(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
        total++;
        if ({bus.busy, bus.kind, bus.fn2, bus.rd1, bus.disp} !== {1'b1, 4'h3, 2'b00, 8'h10, 8'h00}) begin
            bad++;
            $display("FAIL copy_first_drive got=%h want=%h",
                     {bus.busy, bus.kind, bus.fn2, bus.rd1, bus.disp}, {1'b1, 4'h3, 2'b00, 8'h10, 8'h00});
        end
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL copy_done got=timeout want=done"); end
        ref_copy(8'h10, 8'h80, 4);
        @(negedge ck);
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++; $display("FAIL copy_idle got=%b want=00", {bus.busy, bus.done});
        end
        total++;
        if (done_count - d0 != 1) begin
            bad++; $display("FAIL copy_done_pulses got=%0d want=1", done_count - d0);
        end
        total++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]} !== 32'hA1B2C3D4) begin
            bad++; $display("FAIL copy_dest got=%h want=a1b2c3d4",
                            {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]});
        end
        nd = mem_diff(first);
        total++;
        if (nd != 0 || wr_count - w0 != 4) begin
            bad++; $display("FAIL copy_mem got=%0d_diffs(first=%0d),writes=%0d want=0_diffs,writes=4",
                            nd, first, wr_count - w0);
        end
    endtask

    task automatic test_fill_wrap();
        int first, nd;
        bit ok;
        randomize_pre();
        load_mem();
        start_xfer(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A);
        total++;
        if ({bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d} !== {4'h3, 2'b01, 8'hFE, 8'h00, 8'h5A}) begin
            bad++; $display("FAIL fill_first_drive got=%h want=%h",
                            {bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d},
                            {4'h3, 2'b01, 8'hFE, 8'h00, 8'h5A});
        end
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fill_done got=timeout want=done"); end
        ref_fill(8'hFE, 4, 8'h5A);
        @(negedge ck);
        total++;
        if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h5A5A5A5A
            || mem[8'h02] !== pre_mem[8'h02]) begin
            bad++; $display("FAIL fill_wrap got=%h,%02h want=5a5a5a5a,%02h",
                            {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, mem[8'h02], pre_mem[8'h02]);
        end
        nd = mem_diff(first);
        total++;
        if (nd != 0) begin bad++; $display("FAIL fill_mem got=%0d_diffs(first=%0d) want=0", nd, first); end
    endtask

    task automatic test_ck2_hold();
        int w0, first, nd;
        bit ok;
        randomize_pre();
        load_mem();
        ck2_mode = 1;
        @(negedge ck);
        w0 = wr_count;
        start_xfer(1'b0, 8'h30, 8'h90, 9'd3, 8'h00);
        repeat (11) @(negedge ck);
        total++;
        if (wr_count != w0 || {bus.busy, bus.fn2, bus.disp} !== {1'b1, 2'b01, 8'h00}) begin
            bad++; $display("FAIL hold_frozen got=writes%0d,%h want=writes0,%h",
                            wr_count - w0, {bus.busy, bus.fn2, bus.disp}, {1'b1, 2'b01, 8'h00});
        end
        ck2_mode = 0;
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_done got=timeout want=done"); end
        ref_copy(8'h30, 8'h90, 3);
        @(negedge ck);
        nd = mem_diff(first);
        total++;
        if (nd != 0 || wr_count - w0 != 3) begin
            bad++; $display("FAIL hold_mem got=%0d_diffs,writes=%0d want=0,3", nd, wr_count - w0);
        end
    endtask

    task automatic test_len0();
        int b0, a0, w0, d0;
        b0 = busy_count; a0 = acc_count; w0 = wr_count; d0 = done_count;
        start_xfer(1'b0, 8'h11, 8'h22, 9'd0, 8'h33);
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL len0_done got=%b want=10", {bus.done, bus.busy});
        end
        @(negedge ck);
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL len0_pulse got=%b want=0", bus.done); end
        total++;
        if (busy_count != b0 || acc_count != a0 || wr_count != w0 || done_count - d0 != 1) begin
            bad++; $display("FAIL len0_quiet got=busy%0d,acc%0d,wr%0d,done%0d want=0,0,0,1",
                            busy_count - b0, acc_count - a0, wr_count - w0, done_count - d0);
        end
    endtask

    task automatic test_ignore_start();
        int w0, d0, first, nd;
        bit ok;
        randomize_pre();
        load_mem();
        w0 = wr_count; d0 = done_count;
        start_xfer(1'b1, 8'h00, 8'h40, 9'd8, 8'h77);
        repeat (3) @(negedge ck);
        start_xfer(1'b0, 8'h00, 8'hC0, 9'd8, 8'h11);
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ignore_done got=timeout want=done"); end
        ref_fill(8'h40, 8, 8'h77);
        @(negedge ck);
        nd = mem_diff(first);
        total++;
        if (nd != 0 || wr_count - w0 != 8 || done_count - d0 != 1) begin
            bad++; $display("FAIL ignore_start got=%0d_diffs,writes=%0d,done=%0d want=0,8,1",
                            nd, wr_count - w0, done_count - d0);
        end
    endtask

    task automatic test_overlap();
        bit ok;
        randomize_pre();
        pre_mem[8'h20] = 8'h01; pre_mem[8'h21] = 8'h02;
        pre_mem[8'h22] = 8'h03; pre_mem[8'h23] = 8'h04;
        load_mem();
        start_xfer(1'b0, 8'h20, 8'h21, 9'd3, 8'h00);
        wait_done(100, ok);
        @(negedge ck);
        total++;
        if (!ok || {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h01010101) begin
            bad++; $display("FAIL overlap got=%h(done=%0d) want=01010101",
                            {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, ok);
        end
    endtask

    task automatic test_reset_mid();
        int w0, d0, n, first, nd;
        bit ok;
        randomize_pre();
        load_mem();
        ck2_mode = 2;
        w0 = wr_count; d0 = done_count; n = 0;
        start_xfer(1'b0, 8'h40, 8'hA0, 9'd16, 8'h00);
        while (wr_count - w0 < 5 && n < 200) begin
            @(posedge ck);
            #1;
            n++;
        end
        res = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d} !== 32'h0) begin
            bad++; $display("FAIL abort_outputs got=%h want=0",
                            {bus.busy, bus.done, bus.kind, bus.fn2, bus.rd1, bus.disp, bus.store_d});
        end
        ref_copy(8'h40, 8'hA0, 5);
        repeat (3) @(negedge ck);
        res = 1'b1;
        repeat (2) @(negedge ck);
        nd = mem_diff(first);
        total++;
        if (nd != 0 || done_count != d0 || wr_count - w0 != 5) begin
            bad++; $display("FAIL abort_mem got=%0d_diffs(first=%0d),done=%0d,writes=%0d want=0,0,5",
                            nd, first, done_count - d0, wr_count - w0);
        end
        ck2_mode = 0;
        start_xfer(1'b1, 8'h00, 8'hA8, 9'd2, 8'hEE);
        wait_done(100, ok);
        ref_fill(8'hA8, 2, 8'hEE);
        @(negedge ck);
        nd = mem_diff(first);
        total++;
        if (!ok || nd != 0) begin
            bad++; $display("FAIL restart got=done%0d,%0d_diffs want=done1,0", ok, nd);
        end
    endtask

    task automatic test_full_256();
        int w0, first, nd;
        bit ok;
        logic [7:0] p;
        randomize_pre();
        load_mem();
        p = 8'($urandom);
        w0 = wr_count;
        start_xfer(1'b1, 8'h00, 8'h37, 9'd256, p);
        wait_done(800, ok);
        ref_fill(8'h37, 256, p);
        @(negedge ck);
        nd = mem_diff(first);
        total++;
        if (!ok || nd != 0 || wr_count - w0 != 256) begin
            bad++; $display("FAIL full256 got=done%0d,%0d_diffs,writes=%0d want=1,0,256",
                            ok, nd, wr_count - w0);
        end
    endtask

    task automatic test_random();
        int w0, d0, first, nd, l;
        bit ok, m;
        logic [7:0] s, d, p;
        for (int it = 0; it < 8; it++) begin
            randomize_pre();
            load_mem();
            ck2_mode = (it % 2 == 0) ? 2 : 0;
            m = 1'($urandom_range(0, 1));
            s = 8'($urandom);
            d = 8'($urandom);
            p = 8'($urandom);
            l = $urandom_range(1, 48);
            w0 = wr_count; d0 = done_count;
            start_xfer(m, s, d, 9'(l), p);
            bus.src = 8'($urandom); bus.pattern = 8'($urandom); bus.mode = ~m;
            wait_done(400, ok);
            if (m) ref_fill(d, l, p);
            else   ref_copy(s, d, l);
            @(negedge ck);
            nd = mem_diff(first);
            total++;
            if (!ok || nd != 0 || wr_count - w0 != l || done_count - d0 != 1) begin
                bad++; $display("FAIL random_%0d got=done%0d,%0d_diffs(first=%0d),writes=%0d,pulses=%0d want=1,0,%0d,1",
                                it, ok, nd, first, wr_count - w0, done_count - d0, l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill_wrap();
        test_ck2_hold();
        test_len0();
        test_ignore_start();
        test_overlap();
        test_reset_mid();
        test_full_256();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
